imem_loader: RTL and testbench

Boot-time loader that fills the single-cycle CPU's 1024-word instruction memory from a byte stream before the core runs. It accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words. It issues one word write per packed word at consecutive word addresses from 0 and holds the CPU in reset until the programmed word count has been written. It sits between the boot/debug byte source and the instruction memory's write port, alongside the CPU's read-only fetch path.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 114 +++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int IMEM_DEPTH     = 1024;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs bytes little-endian into a 32-bit word; one byte per push, no internal latency.
// No backpressure of its own: the caller only pushes when it can take a full word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  localparam int IW = $clog2(BYTES_PER_WORD);

  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (push) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 1'b1;
    end
  end

  // High while the next push will complete the word.
  assign full = (idx == IW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream, one word write per 4 accepted bytes (5 cycles/word).
// Stalls on low byte_valid; byte_ready drops during the write cycle and outside a load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  loader_state_t state;
  logic [AW:0]   word_idx;
  logic [AW:0]   n_target;
  logic [AW:0]   n_clamped;
  logic [AW:0]   idx_next;
  logic          push;
  logic          full;
  logic          start_acc;
  logic          pack_clr;

  assign n_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign idx_next  = word_idx + 1'b1;
  assign push      = byte_valid & byte_ready;
  assign start_acc = start & ((state == IDLE) | (state == DONE));
  // Byte index restarts both on a new load and after each word is written.
  assign pack_clr  = start_acc | (state == WRITE);
  assign waddr     = word_idx[AW-1:0];

  byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pack_clr),
    .push    (push),
    .byte_in (byte_in),
    .word    (wdata),
    .full    (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
      word_idx   <= '0;
      n_target   <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_target <= n_clamped;
            word_idx <= '0;
            if (n_clamped == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state      <= LOAD;
              done       <= 1'b0;
              cpu_hold   <= 1'b1;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (push && full) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            we         <= 1'b1;
          end
        end
        WRITE: begin
          word_idx <= idx_next;
          if (idx_next == n_target) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            state      <= LOAD;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at start, a monitor pops them on we.
module tb_imem_loader;

  localparam int DEPTH = imem_loader_pkg::IMEM_DEPTH;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stream[$];
  int         stall_at[$];
  int         restart_at = -1;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_we = 0;
  int         last_addr = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (we) begin
      n_we++;
      last_addr = int'(waddr);
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", 32'(waddr), 32'(e.a));
        check("wdata", wdata, e.d);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: N = min(count, DEPTH); word k is bytes 4k..4k+3, first byte least significant.
  task automatic do_start(input int wc, input bit push_exp);
    int n;
    n = (wc > DEPTH) ? DEPTH : wc;
    if (push_exp) begin
      for (int k = 0; k < n; k++) begin
        wr_t e;
        e.a = AW'(k);
        e.d = {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]};
        exp_q.push_back(e);
      end
    end
    start      = 1'b1;
    word_count = (AW + 1)'(wc);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int bound;
    bound      = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    forever begin
      ok = byte_ready;
      tick();
      if (ok) break;
      bound++;
      if (bound > 50) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input int nbytes, output int first_acc);
    first_acc = 0;
    for (int i = 0; i < nbytes; i++) begin
      int st;
      st = 0;
      foreach (stall_at[j]) if (stall_at[j] == i) st++;
      repeat (st) tick();
      if (i == restart_at) begin
        start      = 1'b1;
        word_count = (AW + 1)'(1);
        tick();
        start = 1'b0;
        check("restart_ignored_busy", 32'(busy), 32'd1);
      end
      send_byte(stream[i]);
      if (i == 0) first_acc = cyc;
    end
  endtask

  task automatic wait_done(output int dc);
    int k;
    k = 0;
    while (!done && k < 50) begin
      tick();
      k++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("cpu_hold_released", 32'(cpu_hold), 32'd0);
    check("busy_clear_at_done", 32'(busy), 32'd0);
    dc = cyc;
  endtask

  task automatic load_basic_stream();
    logic [7:0] b[8];
    b = '{8'h33, 8'hE2, 8'h62, 8'h00, 8'h23, 8'h24, 8'hB6, 8'h00};
    stream.delete();
    foreach (b[i]) stream.push_back(b[i]);
  endtask

  initial begin
    int fa, dc, base;

    // Reset state
    #12;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Zero count from IDLE
    stream.delete();
    do_start(0, 1'b1);
    check("zero_done", 32'(done), 32'd1);
    check("zero_cpu_hold", 32'(cpu_hold), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (3) tick();

    // Basic load
    load_basic_stream();
    stall_at.delete();
    do_start(2, 1'b1);
    check("basic_hold", 32'(cpu_hold), 32'd1);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_done_cleared", 32'(done), 32'd0);
    send_stream(8, fa);
    wait_done(dc);
    check("basic_latency", 32'(dc - fa), 32'd9);
    repeat (2) tick();

    // Same stream with 3 single-cycle stalls inside words
    load_basic_stream();
    stall_at.delete();
    for (int s = 0; s < 3; s++) begin
      int p;
      p = $urandom_range(0, 5);
      stall_at.push_back((p < 3) ? p + 1 : p + 2);
    end
    do_start(2, 1'b1);
    check("stall_hold", 32'(cpu_hold), 32'd1);
    send_stream(8, fa);
    wait_done(dc);
    check("stall_latency", 32'(dc - fa), 32'd12);
    stall_at.delete();
    repeat (2) tick();

    // Clamp with a start pulse mid-load that must be ignored
    stream.delete();
    for (int i = 0; i < 4 * DEPTH; i++) stream.push_back(8'($urandom));
    n_we       = 0;
    restart_at = 41;
    do_start(2000, 1'b1);
    send_stream(4 * DEPTH, fa);
    restart_at = -1;
    wait_done(dc);
    check("clamp_we_count", 32'(n_we), 32'(DEPTH));
    check("clamp_last_addr", 32'(last_addr), 32'(DEPTH - 1));

    // Bytes offered in DONE are refused
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    repeat (3) begin
      tick();
      check("done_refuses_bytes", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;

    // Reset mid-load discards the partial word
    stream.delete();
    stream.push_back(8'h11);
    stream.push_back(8'h22);
    do_start(1, 1'b0);
    send_byte(stream[0]);
    send_byte(stream[1]);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_wdata", wdata, 32'd0);
    repeat (3) begin
      tick();
      check("midrst_no_we", 32'(we), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Fresh single-word load after reset
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
    do_start(1, 1'b1);
    send_stream(4, fa);
    wait_done(dc);
    check("single_latency", 32'(dc - fa), 32'd4);

    // Start in DONE reasserts cpu_hold and reloads
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
    base = n_we;
    do_start(1, 1'b1);
    check("reload_hold", 32'(cpu_hold), 32'd1);
    check("reload_done_cleared", 32'(done), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
    send_stream(4, fa);
    wait_done(dc);
    check("reload_we_count", 32'(n_we - base), 32'd1);

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
